// File: rtl/vx_dispatch_arb_if.sv
// Dispatch lanes -> execute unit handshake bundle.
// Master drives lane requests and the sink ready; slave is the arbiter.
interface vx_dispatch_arb_if #(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 64
);
  localparam int LANEW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]       in_valid;
  logic [NUM_LANES*DATAW-1:0] in_data;
  logic [NUM_LANES-1:0]       in_ready;
  logic                       out_valid;
  logic [DATAW-1:0]           out_data;
  logic [LANEW-1:0]           out_lane;
  logic                       out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane
  );
endinterface

// File: rtl/vx_dispatch_arb.sv
// Round-robin arbiter of N dispatch lanes into one execute unit,
// buffered by a 2-entry FIFO of {lane, payload}.
module vx_dispatch_arb #(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 64,
  parameter int PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  vx_dispatch_arb_if.slave     bus,
  output logic [PERF_BITS-1:0] perf_stalls
);
  localparam int LANEW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LANEW-1:0]     rr_ptr;
  logic [LANEW-1:0]     grant_lane;
  logic [NUM_LANES-1:0] grant;
  logic                 found;
  int unsigned          scan;

  logic [LANEW-1:0] mem_lane [2];
  logic [DATAW-1:0] mem_data [2];
  logic             head;
  logic             tail;
  logic [1:0]       count;

  logic can_accept;
  logic push;
  logic pop;

  // can_accept depends on registered count only, so out_ready
  // never reaches in_ready combinationally.
  assign can_accept = (count != 2'd2);

  always_comb begin
    found      = 1'b0;
    grant_lane = '0;
    scan       = 0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan = (int'(rr_ptr) + k) % NUM_LANES;
      if (!found && bus.in_valid[LANEW'(scan)]) begin
        found      = 1'b1;
        grant_lane = LANEW'(scan);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (can_accept && found && !reset)
      grant = NUM_LANES'(1) << grant_lane;
  end

  assign bus.in_ready  = grant;
  assign push          = |grant;
  assign bus.out_valid = (count != 2'd0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_data  = bus.out_valid ? mem_data[head] : '0;
  assign bus.out_lane  = bus.out_valid ? mem_lane[head] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      perf_stalls <= '0;
      mem_lane[0] <= '0;
      mem_lane[1] <= '0;
      mem_data[0] <= '0;
      mem_data[1] <= '0;
    end else begin
      if (push) begin
        mem_lane[tail] <= grant_lane;
        mem_data[tail] <= bus.in_data[int'(grant_lane)*DATAW +: DATAW];
        tail           <= ~tail;
        if (int'(grant_lane) == NUM_LANES - 1)
          rr_ptr <= '0;
        else
          rr_ptr <= grant_lane + LANEW'(1);
      end
      if (pop)
        head <= ~head;
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
      if (|bus.in_valid && !push)
        perf_stalls <= perf_stalls + PERF_BITS'(1);
    end
  end
endmodule

// File: tb/tb_vx_dispatch_arb.sv
// Scoreboard bench for vx_dispatch_arb (4 lanes, 64-bit payload,
// 4-bit stall counter so wrap is reachable).
module tb_vx_dispatch_arb;
  typedef struct {
    logic [1:0]  lane;
    logic [63:0] data;
  } ent_t;

  logic       clk;
  logic       reset;
  logic [3:0] perf_stalls;

  vx_dispatch_arb_if #(.NUM_LANES(4), .DATAW(64)) bus ();

  vx_dispatch_arb #(
    .NUM_LANES(4),
    .DATAW(64),
    .PERF_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .perf_stalls(perf_stalls)
  );

  int checks;
  int failures;

  ent_t       q[$];
  int         mcount;
  int         mrr;
  logic [3:0] mstall;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic rand_data();
    for (int l = 0; l < 4; l++)
      bus.in_data[l*64 +: 64] = rnd64();
  endtask

  task automatic model_clear();
    q.delete();
    mcount = 0;
    mrr    = 0;
    mstall = 4'd0;
  endtask

  // Entry at posedge+1; checks at posedge+2; returns at next posedge+1.
  task automatic step();
    logic [3:0] er;
    int         gl;
    logic       push;
    logic       pop;
    ent_t       e;
    #1;
    er = 4'b0000;
    gl = 0;
    if (mcount < 2)
      for (int k = 0; k < 4; k++) begin
        if (er == 4'b0000 && bus.in_valid[(mrr + k) % 4]) begin
          gl     = (mrr + k) % 4;
          er[gl] = 1'b1;
        end
      end
    checks++;
    if (bus.in_ready !== er) begin
      failures++;
      $display("FAIL in_ready got=%b exp=%b t=%0t", bus.in_ready, er, $time);
    end
    checks++;
    if (bus.out_valid !== (mcount > 0)) begin
      failures++;
      $display("FAIL out_valid got=%b exp=%0d t=%0t", bus.out_valid, mcount > 0, $time);
    end
    if (mcount > 0) begin
      checks++;
      if (bus.out_data !== q[0].data || bus.out_lane !== q[0].lane) begin
        failures++;
        $display("FAIL out_entry got=%0d/%h exp=%0d/%h t=%0t",
                 bus.out_lane, bus.out_data, q[0].lane, q[0].data, $time);
      end
    end
    checks++;
    if (perf_stalls !== mstall) begin
      failures++;
      $display("FAIL perf_stalls got=%0d exp=%0d t=%0t", perf_stalls, mstall, $time);
    end
    push = (er != 4'b0000);
    pop  = (mcount > 0) && bus.out_ready;
    if (pop) begin
      e = q.pop_front();
      mcount--;
    end
    if (push) begin
      e.lane = 2'(gl);
      e.data = bus.in_data[gl*64 +: 64];
      q.push_back(e);
      mcount++;
      mrr = (gl + 1) % 4;
    end
    if (|bus.in_valid && !push)
      mstall = mstall + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    rand_data();
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b/%b exp=0000/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (perf_stalls !== 4'd0 || bus.out_data !== 64'd0 || bus.out_lane !== 2'd0) begin
      failures++;
      $display("FAIL reset_out got=%0d/%h/%0d exp=0/0/0",
               perf_stalls, bus.out_data, bus.out_lane);
    end
    reset = 1'b0;
    model_clear();
    // first edge after release must grant lane 0
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_lane !== 2'd0) begin
      failures++;
      $display("FAIL first_grant got=%b/%0d exp=1/0", bus.out_valid, bus.out_lane);
    end
  endtask

  task automatic test_single_lane();
    do_reset();
    rand_data();
    bus.in_data[2*64 +: 64] = 64'hA5;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_rdy got=%b exp=0100", bus.in_ready);
    end
    step();
    bus.in_valid = 4'b0000;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5 || bus.out_lane !== 2'd2) begin
      failures++;
      $display("FAIL single_out got=%b/%h/%0d exp=1/a5/2",
               bus.out_valid, bus.out_data, bus.out_lane);
    end
    step();
    bus.in_valid = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL single_rr got=%b exp=1000", bus.in_ready);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_data();
      want = 4'b0001 << (i % 4);
      #1;
      checks++;
      if (bus.in_ready !== want) begin
        failures++;
        $display("FAIL rr_seq[%0d] got=%b exp=%b", i, bus.in_ready, want);
      end
      step();
    end
    checks++;
    if (perf_stalls !== 4'd0) begin
      failures++;
      $display("FAIL rr_stalls got=%0d exp=0", perf_stalls);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] lane0;
    do_reset();
    rand_data();
    lane0         = bus.in_data[63:0];
    bus.in_valid  = 4'b0011;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      step();
    #1;
    checks++;
    if (perf_stalls !== 4'd4 || bus.out_data !== lane0 || bus.in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_hold got=%0d/%h/%b exp=4/%h/0000",
               perf_stalls, bus.out_data, bus.in_ready, lane0);
    end
    bus.in_valid  = 4'b0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      step();
  endtask

  task automatic test_push_pop();
    do_reset();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      step();
    end
    checks++;
    if (mcount != 1 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_count got=%b exp=1", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    rand_data();
    for (int i = 0; i < 4; i++)
      step();
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || perf_stalls !== 4'd0 || bus.in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0000",
               bus.out_valid, perf_stalls, bus.in_ready);
    end
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 4'b0000;
    model_clear();
    for (int i = 0; i < 3; i++)
      step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b0;
    rand_data();
    for (int i = 0; i < 19; i++)
      step();
    checks++;
    if (perf_stalls !== 4'd1) begin
      failures++;
      $display("FAIL wrap got=%0d exp=1", perf_stalls);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step();
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    #1;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
